// File: rtl/mux_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mux_rr_sched_if
//
// Bundle of the request/data inputs and the grant/output-stage signals of the
// 4-requester round-robin scheduler.
//
//   req     : 4-bit request vector, bit i = requester i
//   din     : packed data, requester i on din[i*WIDTH +: WIDTH]
//   gnt     : registered one-hot grant, zero when idle
//   sel     : registered mux select, index of the granted requester
//   q       : registered data of the last transfer
//   q_valid : high for the cycle after each transfer edge
//   q_src   : index of the requester that produced q
//
// Modports:
//   master : producer side, drives req/din and observes the outputs
//   slave  : scheduler side, samples req/din and drives the outputs
// -----------------------------------------------------------------------------
interface mux_rr_sched_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   q;
    logic               q_valid;
    logic [1:0]         q_src;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  q,
        input  q_valid,
        input  q_src
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output q,
        output q_valid,
        output q_src
    );
endinterface

// File: rtl/mux_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_rr_sched
//
// Round-robin scheduler for four requesters in front of an 8-bit DFF + 4:1 mux
// output stage. One requester is granted at a time, for a burst of up to
// MAX_BURST transfers. Every edge on which the granted requester still
// requests is a transfer: its data is registered into q together with a valid
// flag and a source tag. When a grant ends, the next requester is chosen in
// the same edge, so continuous requests keep one transfer per cycle.
//
// Parameters:
//   WIDTH     : data width per requester and of q
//   MAX_BURST : maximum consecutive transfers per grant (1..16)
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : mux_rr_sched_if.slave (req, din in; gnt, sel, q, q_valid, q_src out)
//
// Optional feature:
//   SCHED_FIXED_PRIO_EN : when defined, arbitration always scans from index 0
//   (lowest index wins) and the round-robin pointer is removed. MAX_BURST
//   still ends grants, but a lower index that keeps requesting wins again.
// -----------------------------------------------------------------------------
module mux_rr_sched #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_rr_sched_if.slave        bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t           state_r, state_n;
    logic [3:0]       gnt_r,   gnt_n;
    logic [1:0]       sel_r,   sel_n;
    logic [3:0]       cnt_r,   cnt_n;
    logic [WIDTH-1:0] q_r,     q_n;
    logic             q_valid_r, q_valid_n;
    logic [1:0]       q_src_r, q_src_n;
`ifndef SCHED_FIXED_PRIO_EN
    logic [1:0]       ptr_r,   ptr_n;
`endif

    logic [1:0]       idle_start;
    logic [1:0]       regrant_start;
    logic             xfer;
    logic             grant_end;
    logic [1:0]       idle_win;
    logic [1:0]       regrant_win;

    // First requesting index found scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] win(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        logic [1:0] w;
        w     = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Scan origins: round-robin starts at the pointer when idle and just past
    // the expiring requester on a handoff, so the expiring one ranks last.
`ifdef SCHED_FIXED_PRIO_EN
    assign idle_start    = 2'd0;
    assign regrant_start = 2'd0;
`else
    assign idle_start    = ptr_r;
    assign regrant_start = sel_r + 2'd1;
`endif

    assign xfer        = bus.req[sel_r];
    assign grant_end   = !xfer || (cnt_r == CNT_LAST);
    assign idle_win    = win(bus.req, idle_start);
    assign regrant_win = win(bus.req, regrant_start);

    // Next-state logic. Everything holds by default and q_valid drops unless
    // this edge is a transfer. A handoff overrides the counter increment.
    always_comb begin
        state_n   = state_r;
        gnt_n     = gnt_r;
        sel_n     = sel_r;
        cnt_n     = cnt_r;
        q_n       = q_r;
        q_valid_n = 1'b0;
        q_src_n   = q_src_r;
`ifndef SCHED_FIXED_PRIO_EN
        ptr_n     = ptr_r;
`endif
        case (state_r)
            IDLE: begin
                if (|bus.req) begin
                    gnt_n   = onehot(idle_win);
                    sel_n   = idle_win;
                    cnt_n   = 4'd0;
                    state_n = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    q_n       = bus.din[sel_r*WIDTH +: WIDTH];
                    q_src_n   = sel_r;
                    q_valid_n = 1'b1;
                    cnt_n     = cnt_r + 4'd1;
                end
                if (grant_end) begin
`ifndef SCHED_FIXED_PRIO_EN
                    ptr_n = sel_r + 2'd1;
`endif
                    if (|bus.req) begin
                        gnt_n = onehot(regrant_win);
                        sel_n = regrant_win;
                        cnt_n = 4'd0;
                    end else begin
                        gnt_n   = 4'd0;
                        cnt_n   = 4'd0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'd0;
            end
        endcase
    end

    // State registers; reset wins over any transfer or handoff on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            gnt_r     <= 4'd0;
            sel_r     <= 2'd0;
            cnt_r     <= 4'd0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            q_src_r   <= 2'd0;
`ifndef SCHED_FIXED_PRIO_EN
            ptr_r     <= 2'd0;
`endif
        end else begin
            state_r   <= state_n;
            gnt_r     <= gnt_n;
            sel_r     <= sel_n;
            cnt_r     <= cnt_n;
            q_r       <= q_n;
            q_valid_r <= q_valid_n;
            q_src_r   <= q_src_n;
`ifndef SCHED_FIXED_PRIO_EN
            ptr_r     <= ptr_n;
`endif
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.sel     = sel_r;
    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
    assign bus.q_src   = q_src_r;

endmodule

// File: tb/tb_mux_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_sched
//
// Directed bench for mux_rr_sched with WIDTH=8, MAX_BURST=2. Inputs are driven
// 1 time unit after a rising edge and outputs are sampled at the same point,
// so each check sees the registers updated by the edge just taken.
// -----------------------------------------------------------------------------
module tb_mux_rr_sched;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 2;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    mux_rr_sched_if #(.WIDTH(WIDTH)) bus ();

    mux_rr_sched #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        bus.req = r;
        bus.din = d;
    endtask

    task automatic checkOne(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                               input logic [7:0] e_q, input logic e_qv, input logic [1:0] e_src);
        checkOne({tag, ".gnt"},     8'(bus.gnt),     8'(e_gnt));
        checkOne({tag, ".sel"},     8'(bus.sel),     8'(e_sel));
        checkOne({tag, ".q"},       bus.q,           e_q);
        checkOne({tag, ".q_valid"}, 8'(bus.q_valid), 8'(e_qv));
        checkOne({tag, ".q_src"},   8'(bus.q_src),   8'(e_src));
    endtask

    logic [31:0] din_inc;
    logic [1:0]  e_src;
    logic [1:0]  e_own;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        din_inc      = {8'h13, 8'h12, 8'h11, 8'h10};
        rst          = 1'b1;
        applyStimulus(4'b1111, din_inc);

        // Reset held two edges with every requester active.
        tick();
        tick();
        checkOutput("reset", 4'b0000, 2'd0, 8'h00, 1'b0, 2'd0);

        // Release: first grant goes to requester 0, no transfer yet.
        rst = 1'b0;
        tick();
        checkOutput("first_grant", 4'b0001, 2'd0, 8'h00, 1'b0, 2'd0);

        // All requesting, bursts of two: sources 0,0,1,1,2,2,3,3,0,0.
        for (int k = 0; k < 10; k++) begin
            tick();
`ifdef SCHED_FIXED_PRIO_EN
            e_src = 2'd0;
            e_own = 2'd0;
`else
            e_src = 2'((k / 2) % 4);
            e_own = 2'(((k + 1) / 2) % 4);
`endif
            checkOutput($sformatf("rr_%0d", k), 4'b0001 << e_own, e_own,
                        8'h10 + 8'(e_src), 1'b1, e_src);
        end

        // Reset in the middle of a grant clears everything.
        rst = 1'b1;
        tick();
        checkOutput("mid_reset", 4'b0000, 2'd0, 8'h00, 1'b0, 2'd0);
        rst = 1'b0;
        tick();
        checkOutput("post_reset_grant", 4'b0001, 2'd0, 8'h00, 1'b0, 2'd0);

        // Sole requester: continuous transfers across burst boundaries.
        applyStimulus(4'b0001, 32'h0000_00A5);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("sole_%0d", k), 4'b0001, 2'd0, 8'hA5, 1'b1, 2'd0);
        end

        // Mid-burst drop: requester 0 then requester 2, one bubble between.
        rst = 1'b1;
        applyStimulus(4'b0101, {8'h00, 8'h5A, 8'h00, 8'hA5});
        tick();
        rst = 1'b0;
        tick();
        checkOutput("drop_grant", 4'b0001, 2'd0, 8'h00, 1'b0, 2'd0);
        tick();
        checkOutput("drop_xfer0", 4'b0001, 2'd0, 8'hA5, 1'b1, 2'd0);
        applyStimulus(4'b0100, {8'h00, 8'h5A, 8'h00, 8'hA5});
        tick();
        checkOutput("drop_bubble", 4'b0100, 2'd2, 8'hA5, 1'b0, 2'd0);
        tick();
        checkOutput("drop_xfer2", 4'b0100, 2'd2, 8'h5A, 1'b1, 2'd2);

        // Requests vanish: back to idle, sel and q hold.
        applyStimulus(4'b0000, {8'h00, 8'h5A, 8'h00, 8'hA5});
        tick();
        checkOutput("to_idle", 4'b0000, 2'd2, 8'h5A, 1'b0, 2'd2);
        tick();
        checkOutput("idle_hold", 4'b0000, 2'd2, 8'h5A, 1'b0, 2'd2);

        // From idle the pointer sits just past requester 2, so 3 beats 0.
        applyStimulus(4'b1001, {8'h77, 8'h00, 8'h00, 8'h66});
        tick();
`ifdef SCHED_FIXED_PRIO_EN
        checkOutput("idle_ptr", 4'b0001, 2'd0, 8'h5A, 1'b0, 2'd2);
`else
        checkOutput("idle_ptr", 4'b1000, 2'd3, 8'h5A, 1'b0, 2'd2);
        tick();
        checkOutput("idle_ptr_xfer", 4'b1000, 2'd3, 8'h77, 1'b1, 2'd3);
        tick();
        checkOutput("idle_ptr_handoff", 4'b0001, 2'd0, 8'h77, 1'b1, 2'd3);
        tick();
        checkOutput("idle_ptr_xfer0", 4'b0001, 2'd0, 8'h66, 1'b1, 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
